rename_regfile: RTL
===================

Name: rename_regfile

Overview:
- Parametrised architectural register file with per-register rename tags for the out-of-order core.
- Sits between decode/issue, which reads sources and renames the destination, and the ROB, which commits results.
- Successor to the single-channel rename file, adding:
  - configurable register count, data width, ROB tag width and read-port count;
  - a hardwired x0;
  - same-cycle issue and commit, with neither dropped;
  - tag outputs for busy sources;
  - a global flush on mispredict.

Parameters:
NUM_REGS, 32, number of architectural registers (power of two); register 0 hardwired to zero
XLEN, 32, data width
ROB_IDX_W, 4, ROB tag width
NUM_RD, 2, number of read ports
ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rdy  in  1  global enable; low = all state frozen
flush  in  1  mispredict flush; clears every busy bit
rs_addr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
rs_ready  out  NUM_RD  1 = value valid (register not renamed)
rs_val  out  NUM_RD*XLEN  register value
rs_tag  out  NUM_RD*ROB_IDX_W  ROB tag of the pending producer; 0 when ready
issue_en  in  1  rename destination issue_rd to issue_tag
issue_rd  in  ADDR_W  destination register
issue_tag  in  ROB_IDX_W  ROB entry of the issuing instruction
commit_en  in  1  ROB commit of a result
commit_rd  in  ADDR_W  committed destination register
commit_tag  in  ROB_IDX_W  ROB entry being committed
commit_val  in  XLEN  committed value

Behaviour:
- State per register: val[XLEN], busy, tag[ROB_IDX_W].
- Reset (rst low, asynchronous): all val = 0, busy = 0, tag = 0.
  - Consequently every read port outputs rs_ready = 1, rs_val = 0, rs_tag = 0.
  - Reset deasserted mid-operation: normal operation resumes on the first rising edge with rst high.
- Reads are combinational from current state, with zero latency.
  - rs_ready = !busy.
  - rs_tag = busy ? tag : 0.
  - Same-cycle issue is not visible to reads; the issuing instruction reads its sources pre-rename.
- Register 0:
  - issue and commit to it are ignored;
  - reads always return ready = 1, val = 0, tag = 0.
- All updates occur on the rising clk edge and only when rdy = 1. When rdy = 0, no state changes.
- Commit (commit_en, commit_rd != 0):
  - val[commit_rd] <= commit_val unconditionally.
  - busy is cleared only if busy[commit_rd] = 1 and tag[commit_rd] == commit_tag. A tag mismatch means a younger rename exists, so busy is kept.
- Issue (issue_en, issue_rd != 0): busy[issue_rd] <= 1, tag[issue_rd] <= issue_tag.
- Issue and commit in the same cycle:
  - both take effect;
  - if the same register is targeted, the value is written and issue wins busy/tag (busy = 1, tag = issue_tag).
- Flush:
  - all busy <= 0 and all tag <= 0;
  - issue in the same cycle is ignored;
  - commit in the same cycle still writes val, because the committing instruction is older than the flush point.
- Single cycle per operation; no back-pressure and no internal FSM beyond the busy/tag state.

Optional Feature:
- Macro RENAME_RF_COMMIT_BYPASS_EN.
- Defined: a read port whose rs_addr equals commit_rd (nonzero), with commit_en = 1, busy = 1 and tag == commit_tag, returns in the same cycle:
  - rs_ready = 1;
  - rs_val = commit_val;
  - rs_tag = 0.
  - This is independent of rdy and flush.
- Undefined: the committed value becomes visible the following cycle only.

Decomposition:
- Shared package rename_pkg holds:
  - XLEN, ROB_IDX_W and NUM_REGS defaults;
  - typedefs reg_addr_t, rob_tag_t and xlen_t.
- One natural sub-module: rf_read_port, instantiated NUM_RD times via generate. It performs the address mux, the x0 override and the optional commit bypass.

Test Plan:
- Reset: drive rst low asynchronously mid-cycle -> immediately all rs_ready = 1, rs_val = 0, rs_tag = 0; no clk edge needed.
- Tag matching:
  - issue r5 tag 3, then r5 tag 7;
  - commit r5 tag 3 val 0xAA -> r5 val 0xAA, still busy, rs_tag = 7;
  - commit r5 tag 7 val 0xBB -> r5 ready, val 0xBB.
- Same-cycle issue and commit on r9:
  - setup: r9 busy with tag 2;
  - stimulus: issue r9 tag 4 and commit r9 tag 2 val 0x11;
  - response: next cycle val 0x11, busy, rs_tag = 4.
- Flush:
  - setup: r1, r2 and r3 busy;
  - stimulus: flush together with commit r2 val 0x55 and issue r4 tag 1;
  - response: r1–r4 all ready, r2 = 0x55, r4 not renamed.
- x0 and rdy:
  - issue or commit to r0 -> reads still 0/ready;
  - rdy = 0 with issue r6 tag 1 -> r6 unchanged.
- Bypass, with the macro defined:
  - setup: r8 busy with tag 5;
  - stimulus: commit r8 tag 5 val 0x1234 while a port reads r8;
  - response: same cycle ready = 1, val 0x1234.
  - Without the macro: ready = 0 that cycle and ready = 1 the next.

Source files
------------

// File: rtl/rename_regfile_pkg.sv
// Shared defaults and typedefs for the rename register file and its read ports.
package rename_pkg;

  localparam int RF_NUM_REGS  = 32;
  localparam int RF_XLEN      = 32;
  localparam int RF_ROB_IDX_W = 4;

  typedef logic [$clog2(RF_NUM_REGS)-1:0] reg_addr_t;
  typedef logic [RF_ROB_IDX_W-1:0]        rob_tag_t;
  typedef logic [RF_XLEN-1:0]             xlen_t;

endpackage

// File: rtl/rename_regfile_rf_read_port.sv
// One combinational read port: address mux, x0 override and, when
// RENAME_RF_COMMIT_BYPASS_EN is defined, a same-cycle commit bypass.
module rf_read_port
  import rename_pkg::*;
#(
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int XLEN      = RF_XLEN,
  parameter int ROB_IDX_W = RF_ROB_IDX_W,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [NUM_REGS-1:0][XLEN-1:0]       rf_val,
  input  logic [NUM_REGS-1:0]                 rf_busy,
  input  logic [NUM_REGS-1:0][ROB_IDX_W-1:0]  rf_tag,
`ifdef RENAME_RF_COMMIT_BYPASS_EN
  input  logic                                commit_en,
  input  logic [ADDR_W-1:0]                   commit_rd,
  input  logic [ROB_IDX_W-1:0]                commit_tag,
  input  logic [XLEN-1:0]                     commit_val,
`endif
  output logic                                ready,
  output logic [XLEN-1:0]                     val,
  output logic [ROB_IDX_W-1:0]                tag
);

  always_comb begin
    ready = 1'b1;
    val   = '0;
    tag   = '0;
    if (addr != '0) begin
      ready = !rf_busy[addr];
      val   = rf_val[addr];
      tag   = rf_busy[addr] ? rf_tag[addr] : '0;
`ifdef RENAME_RF_COMMIT_BYPASS_EN
      // Only the commit that retires the current rename may be forwarded.
      if (commit_en && (commit_rd == addr) && rf_busy[addr] &&
          (rf_tag[addr] == commit_tag)) begin
        ready = 1'b1;
        val   = commit_val;
        tag   = '0;
      end
`endif
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags, x0 hardwired,
// flush on mispredict; optional commit bypass via RENAME_RF_COMMIT_BYPASS_EN.
module rename_regfile
  import rename_pkg::*;
#(
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int XLEN      = RF_XLEN,
  parameter int ROB_IDX_W = RF_ROB_IDX_W,
  parameter int NUM_RD    = 2,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          flush,
  input  logic [NUM_RD*ADDR_W-1:0]      rs_addr,
  output logic [NUM_RD-1:0]             rs_ready,
  output logic [NUM_RD*XLEN-1:0]        rs_val,
  output logic [NUM_RD*ROB_IDX_W-1:0]   rs_tag,
  input  logic                          issue_en,
  input  logic [ADDR_W-1:0]             issue_rd,
  input  logic [ROB_IDX_W-1:0]          issue_tag,
  input  logic                          commit_en,
  input  logic [ADDR_W-1:0]             commit_rd,
  input  logic [ROB_IDX_W-1:0]          commit_tag,
  input  logic [XLEN-1:0]               commit_val
);

  logic [NUM_REGS-1:0][XLEN-1:0]      val_q, val_d;
  logic [NUM_REGS-1:0]                busy_q, busy_d;
  logic [NUM_REGS-1:0][ROB_IDX_W-1:0] tag_q, tag_d;

  // Commit is evaluated first so a same-register issue overrides busy/tag.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy) begin
      if (commit_en && (commit_rd != '0)) begin
        val_d[commit_rd] = commit_val;
        if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag)) begin
          busy_d[commit_rd] = 1'b0;
        end
      end
      if (flush) begin
        busy_d = '0;
        tag_d  = '0;
      end else if (issue_en && (issue_rd != '0)) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .NUM_REGS  (NUM_REGS),
      .XLEN      (XLEN),
      .ROB_IDX_W (ROB_IDX_W)
    ) u_port (
      .addr       (rs_addr[p*ADDR_W +: ADDR_W]),
      .rf_val     (val_q),
      .rf_busy    (busy_q),
      .rf_tag     (tag_q),
`ifdef RENAME_RF_COMMIT_BYPASS_EN
      .commit_en  (commit_en),
      .commit_rd  (commit_rd),
      .commit_tag (commit_tag),
      .commit_val (commit_val),
`endif
      .ready      (rs_ready[p]),
      .val        (rs_val[p*XLEN +: XLEN]),
      .tag        (rs_tag[p*ROB_IDX_W +: ROB_IDX_W])
    );
  end

endmodule
